// File: rtl/mobilenet_mem_pkg.sv
// Shared memory-path types for the MobileNet accelerator:
// default widths, reader FSM encoding and the FIFO entry layout.
package mobilenet_mem_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 10;
  localparam int DIM_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ifm_state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } ifm_entry_t;

endpackage

// File: rtl/ifm_skid_fifo.sv
// Two-entry register FIFO; slot0 is always the head so the
// output is a plain register with no read mux.
import mobilenet_mem_pkg::*;

module ifm_skid_fifo #(
  parameter int W = $bits(ifm_entry_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q;
  logic [W-1:0] slot1_q;
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign head_o  = slot0_q;
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= push_data_i;
          else                 slot1_q <= push_data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_q <= push_data_i;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifm_reader.sv
// IFM buffer read controller: walks a 2-D tile and streams the
// words out through a credit-limited 2-entry skid FIFO.
import mobilenet_mem_pkg::*;

module ifm_reader #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  rows,
  input  logic [ADDR_W-1:0] row_pitch,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready
);

  ifm_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_start_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] pitch_q;
  logic [DIM_W-1:0]  c_q;
  logic [DIM_W-1:0]  r_q;
  logic [DIM_W-1:0]  cols_q;
  logic [DIM_W-1:0]  rows_q;

  logic [1:0]        fifo_cnt;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic [2:0]        level;
  logic              issue;
  logic              last_col;
  logic              last_row;
  logic              final_addr;
  logic [ADDR_W-1:0] row_next;

  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = fifo_head[DATA_W-1:0];
  assign m_last  = fifo_head[DATA_W];
  assign busy    = busy_q;
  assign done    = done_q;

  assign pop = m_valid && m_ready;

  // Occupancy the FIFO will have after this edge, counting the
  // word already on its way back from the buffer.
  assign level = {1'b0, fifo_cnt} + {2'b0, inflight_q}
               - {2'b0, pop};

  assign issue      = (state_q == ST_RUN) && (level < 3'd2);
  assign last_col   = (c_q == cols_q - DIM_W'(1));
  assign last_row   = (r_q == rows_q - DIM_W'(1));
  assign final_addr = last_col && last_row;
  assign row_next   = row_start_q + pitch_q;
  assign rd_addr    = issue ? addr_q : rd_addr_q;

  ifm_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, rd_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      addr_q          <= '0;
      row_start_q     <= '0;
      rd_addr_q       <= '0;
      pitch_q         <= '0;
      c_q             <= '0;
      r_q             <= '0;
      cols_q          <= '0;
      rows_q          <= '0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && final_addr;
      done_q          <= 1'b0;
      if (issue) begin
        rd_addr_q <= addr_q;
        if (last_col) begin
          c_q         <= '0;
          r_q         <= r_q + DIM_W'(1);
          row_start_q <= row_next;
          addr_q      <= row_next;
        end else begin
          c_q    <= c_q + DIM_W'(1);
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            cols_q      <= cols;
            rows_q      <= rows;
            pitch_q     <= row_pitch;
            addr_q      <= base_addr;
            row_start_q <= base_addr;
            c_q         <= '0;
            r_q         <= '0;
            if (rows == '0 || cols == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue && final_addr) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (level == 3'd0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_reader.sv
// Directed bench for ifm_reader with a 1-cycle-latency buffer
// model (mem[i]=i) and an expected-word scoreboard.
module tb_ifm_reader;

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [9:0]   base_addr;
  logic [9:0]   cols;
  logic [9:0]   rows;
  logic [9:0]   row_pitch;
  logic         busy;
  logic         done;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [127:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;

  int   total;
  int   bad;
  int   done_cnt;
  exp_t sb[$];
  exp_t got_e;
  bit   nonempty;
  bit   stall_q;
  bit   prev_last_xfer;
  logic [127:0] hold_data;
  logic         hold_last;

  ifm_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .cols      (cols),
    .rows      (rows),
    .row_pitch (row_pitch),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= {118'd0, rd_addr};

  task automatic check(input logic [127:0] got,
                       input logic [127:0] exp,
                       input string tag);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_q        = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      if (stall_q) begin
        check(128'(m_valid), 128'd1, "stall_valid");
        check(m_data, hold_data, "stall_data");
        check(128'(m_last), 128'(hold_last), "stall_last");
      end
      if (prev_last_xfer) check(128'(done), 128'd1, "done_after_last");
      if (done) begin
        done_cnt++;
        check(128'(sb.size()), 128'd0, "sb_empty_at_done");
        if (nonempty)
          check(128'(prev_last_xfer), 128'd1, "done_timing");
      end
      check(128'(dut.u_fifo.count_q <= 2'd2), 128'd1, "fifo_cnt");
      prev_last_xfer = 1'b0;
      if (m_valid && m_ready) begin
        check(128'(sb.size() != 0), 128'd1, "unexpected_word");
        if (sb.size() != 0) begin
          got_e = sb.pop_front();
          check(m_data, got_e.data, "word_data");
          check(128'(m_last), 128'(got_e.last), "word_last");
          prev_last_xfer = m_last;
        end
      end
      stall_q   = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
    end
  end

  task automatic start_cmd(input logic [9:0] b, input logic [9:0] c,
                           input logic [9:0] r, input logic [9:0] p);
    exp_t       e;
    logic [9:0] a;
    for (int ri = 0; ri < int'(r); ri++) begin
      for (int ci = 0; ci < int'(c); ci++) begin
        a      = b + 10'(ri * int'(p)) + 10'(ci);
        e.last = (ri == int'(r) - 1) && (ci == int'(c) - 1);
        e.data = {118'd0, a};
        sb.push_back(e);
      end
    end
    nonempty  = (r != 0) && (c != 0);
    base_addr = b;
    cols      = c;
    rows      = r;
    row_pitch = p;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int mode);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (mode == 1)      m_ready = ~m_ready;
      else if (mode == 2) m_ready = 1'b0;
      else                m_ready = 1'b1;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    check(128'(ok), 128'd1, "done_timeout");
    check(128'(sb.size()), 128'd0, "sb_drained");
    m_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    total     = 0;
    bad       = 0;
    done_cnt  = 0;
    nonempty  = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    cols      = '0;
    rows      = '0;
    row_pitch = '0;
    m_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(128'(m_valid), 128'd0, "rst_valid");
    check(128'(busy), 128'd0, "rst_busy");
    check(128'(done), 128'd0, "rst_done");
    check(128'(m_last), 128'd0, "rst_last");
    check(m_data, 128'd0, "rst_data");
    check(128'(rd_addr), 128'd0, "rst_addr");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: full-rate stream and first-word latency
    start_cmd(10'd0, 10'd4, 10'd2, 10'd8);
    @(negedge clk);
    check(128'(busy), 128'd1, "busy_after_start");
    check(128'(m_valid), 128'd0, "lat_e0");
    @(negedge clk);
    check(128'(m_valid), 128'd0, "lat_e1");
    @(negedge clk);
    check(128'(m_valid), 128'd1, "lat_e2");
    wait_done(0);
    check(128'(busy), 128'd0, "idle_busy");

    // 2: same tile with m_ready toggling
    start_cmd(10'd0, 10'd4, 10'd2, 10'd8);
    wait_done(1);

    // 3: address wrap
    start_cmd(10'd1022, 10'd4, 10'd1, 10'd0);
    wait_done(0);

    // 4: empty tiles
    d0 = done_cnt;
    start_cmd(10'd5, 10'd5, 10'd0, 10'd3);
    repeat (3) begin
      @(negedge clk);
      check(128'(busy), 128'd0, "empty_busy_r0");
    end
    check(128'(done_cnt), 128'(d0 + 1), "empty_done_r0");
    d0 = done_cnt;
    start_cmd(10'd5, 10'd0, 10'd3, 10'd3);
    repeat (3) begin
      @(negedge clk);
      check(128'(busy), 128'd0, "empty_busy_c0");
    end
    check(128'(done_cnt), 128'(d0 + 1), "empty_done_c0");
    @(posedge clk);
    #1;

    // 5: restart during RUN is ignored
    start_cmd(10'd40, 10'd3, 10'd3, 10'd5);
    base_addr = 10'd700;
    cols      = 10'd2;
    rows      = 10'd2;
    row_pitch = 10'd1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0);

    // 6: reset mid-tile under backpressure, then a clean tile
    m_ready = 1'b0;
    start_cmd(10'd0, 10'd4, 10'd2, 10'd8);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check(128'(m_valid), 128'd0, "midrst_valid");
    check(128'(busy), 128'd0, "midrst_busy");
    sb.delete();
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(128'(done_cnt), 128'(d0), "midrst_no_done");
    start_cmd(10'd100, 10'd3, 10'd3, 10'd16);
    wait_done(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
